// File: rtl/decode_pipe_stage_if.sv
// rtl/decode_pipe_stage_if.sv - fetch-side and EX-side handshake bundle of the decode stage
// master drives fetch beats and EX backpressure; slave is the decode stage itself.
interface decode_pipe_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [PC_W-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [PC_W-1:0] out_pc_o;
    logic [4:0]      out_rs1_o;
    logic [4:0]      out_rs2_o;
    logic [4:0]      out_rd_o;
    logic [31:0]     out_imm_o;
    logic [19:0]     out_ctrl_o;

    modport master (
        output in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_rs1_o, out_rs2_o, out_rd_o,
               out_imm_o, out_ctrl_o
    );

    modport slave (
        input  in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_rs1_o, out_rs2_o, out_rd_o,
               out_imm_o, out_ctrl_o
    );
endinterface

// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - registered RV32I(M) decode stage with load-use stall and flush
// Decode is combinational from the incoming word; one output register feeds EX.
module decode_pipe_stage #(
    parameter int PC_W        = 32,
    parameter bit ENABLE_M    = 1'b1,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    decode_pipe_stage_if.slave     bus,
    input  logic                   flush_i,
    input  logic                   ex_memread_i,
    input  logic [4:0]             ex_rd_i,
    output logic                   stall_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

    assign w_opcode = bus.instr_i[6:0];
    assign w_funct3 = bus.instr_i[14:12];
    assign w_funct7 = bus.instr_i[31:25];
    assign w_imm_i  = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
    assign w_imm_s  = {{20{bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
    assign w_imm_b  = {{19{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[7],
                       bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
    assign w_imm_u  = {bus.instr_i[31:12], 12'b0};
    assign w_imm_j  = {{11{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[19:12],
                       bus.instr_i[20], bus.instr_i[30:21], 1'b0};
    assign w_imm_sh = {27'b0, bus.instr_i[24:20]};

    logic [3:0]  w_aluop;
    logic        w_alusrc, w_regwrite, w_memread, w_memwrite;
    logic [2:0]  w_width;
    logic [1:0]  w_memtoreg;
    logic        w_jal, w_jalr, w_mul, w_illegal;
    logic [2:0]  w_mulop;
    logic [31:0] w_imm;
    logic        w_use_rs1, w_use_rs2;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [19:0] w_ctrl;

    always_comb begin
        w_aluop    = ALU_ADD;
        w_alusrc   = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_width    = 3'b000;
        w_memtoreg = 2'b00;
        w_jal      = 1'b0;
        w_jalr     = 1'b0;
        w_mul      = 1'b0;
        w_illegal  = 1'b0;
        w_imm      = 32'b0;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = w_imm_u;
            end
            OP_JAL: begin
                w_regwrite = 1'b1;
                w_jal      = 1'b1;
                w_memtoreg = 2'b10;
                w_imm      = w_imm_j;
            end
            OP_JALR: begin
                w_regwrite = 1'b1;
                w_jalr     = 1'b1;
                w_alusrc   = 1'b1;
                w_memtoreg = 2'b10;
                w_imm      = w_imm_i;
                w_use_rs1  = 1'b1;
            end
            OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = w_imm_b;
                case (w_funct3)
                    3'b000:  w_aluop = 4'hA;
                    3'b001:  w_aluop = 4'hB;
                    3'b100:  w_aluop = 4'hC;
                    3'b101:  w_aluop = 4'hD;
                    3'b110:  w_aluop = 4'hE;
                    3'b111:  w_aluop = 4'hF;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
                w_alusrc   = 1'b1;
                w_memtoreg = 2'b01;
                w_imm      = w_imm_i;
                w_use_rs1  = 1'b1;
                // Unsigned loads are renumbered so the width field stays dense.
                case (w_funct3)
                    3'b000:  w_width = 3'b000;
                    3'b001:  w_width = 3'b001;
                    3'b010:  w_width = 3'b010;
                    3'b100:  w_width = 3'b011;
                    3'b101:  w_width = 3'b100;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_imm      = w_imm_s;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_width    = w_funct3;
                w_illegal  = (w_funct3 > 3'b010);
            end
            OP_IMM: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_use_rs1  = 1'b1;
                w_imm      = w_imm_i;
                case (w_funct3)
                    3'b000: w_aluop = ALU_ADD;
                    3'b010: w_aluop = ALU_SLT;
                    3'b011: w_aluop = ALU_SLTU;
                    3'b100: w_aluop = ALU_XOR;
                    3'b110: w_aluop = ALU_OR;
                    3'b111: w_aluop = ALU_AND;
                    3'b001: begin
                        w_aluop   = ALU_SLL;
                        w_imm     = w_imm_sh;
                        w_illegal = (w_funct7 != F7_BASE);
                    end
                    default: begin
                        w_imm = w_imm_sh;
                        if (w_funct7 == F7_BASE)     w_aluop = ALU_SRL;
                        else if (w_funct7 == F7_ALT) w_aluop = ALU_SRA;
                        else                         w_illegal = 1'b1;
                    end
                endcase
            end
            OP_OP: begin
                w_regwrite = 1'b1;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        3'b000:  w_aluop = ALU_ADD;
                        3'b001:  w_aluop = ALU_SLL;
                        3'b010:  w_aluop = ALU_SLT;
                        3'b011:  w_aluop = ALU_SLTU;
                        3'b100:  w_aluop = ALU_XOR;
                        3'b101:  w_aluop = ALU_SRL;
                        3'b110:  w_aluop = ALU_OR;
                        default: w_aluop = ALU_AND;
                    endcase
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_aluop = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_aluop = ALU_SRA;
                end else if (w_funct7 == F7_MULD && ENABLE_M) begin
                    w_mul = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_FENCE: begin
                w_use_rs1 = 1'b1;
                w_imm     = w_imm_i;
            end
            OP_SYSTEM: begin
                w_use_rs1 = 1'b1;
                w_imm     = w_imm_i;
                w_illegal = (w_funct3 == 3'b100);
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal words still travel to EX, but with every side effect suppressed.
        if (w_illegal) begin
            w_regwrite = 1'b0;
            w_memread  = 1'b0;
            w_memwrite = 1'b0;
            w_jal      = 1'b0;
            w_jalr     = 1'b0;
            w_mul      = 1'b0;
            w_aluop    = ALU_ADD;
        end
    end

    assign w_mulop = w_mul ? w_funct3 : 3'b000;
    assign w_rs1   = w_use_rs1  ? bus.instr_i[19:15] : 5'd0;
    assign w_rs2   = w_use_rs2  ? bus.instr_i[24:20] : 5'd0;
    assign w_rd    = w_regwrite ? bus.instr_i[11:7]  : 5'd0;
    assign w_ctrl  = {w_illegal, w_mulop, w_mul, w_jalr, w_jal, w_memtoreg, w_width,
                      w_memwrite, w_memread, w_regwrite, w_alusrc, w_aluop};

    logic                   r_valid;
    logic [PC_W-1:0]        r_pc;
    logic [4:0]             r_rs1, r_rs2, r_rd;
    logic [31:0]            r_imm;
    logic [19:0]            r_ctrl;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_stall, w_ready, w_accept, w_drain;

    assign w_stall  = r_valid && ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == r_rs1) || (ex_rd_i == r_rs2));
    assign w_ready  = flush_i || ((!r_valid || bus.out_ready_i) && !w_stall);
    assign w_accept = bus.in_valid_i && w_ready && !flush_i;
    assign w_drain  = r_valid && !w_stall && bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_imm       <= 32'd0;
            r_ctrl      <= 20'd0;
            r_stall_cnt <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_pc    <= bus.pc_i;
                r_rs1   <= w_rs1;
                r_rs2   <= w_rs2;
                r_rd    <= w_rd;
                r_imm   <= w_imm;
                r_ctrl  <= w_ctrl;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready_o  = w_ready;
    assign bus.out_valid_o = r_valid && !w_stall;
    assign bus.out_pc_o    = r_pc;
    assign bus.out_rs1_o   = r_rs1;
    assign bus.out_rs2_o   = r_rs2;
    assign bus.out_rd_o    = r_rd;
    assign bus.out_imm_o   = r_imm;
    assign bus.out_ctrl_o  = r_ctrl;
    assign stall_o         = w_stall;
    assign stall_cnt_o     = r_stall_cnt;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - bench for decode_pipe_stage (M-enabled/32-bit counter and M-disabled/4-bit counter)
// Both instances share stimulus; a table-driven decoder and a one-slot pipeline model predict every output.
module tb_decode_pipe_stage;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i, ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic        stall_a, stall_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    decode_pipe_stage_if #(.PC_W(32)) bus_a ();
    decode_pipe_stage_if #(.PC_W(32)) bus_b ();

    assign bus_b.in_valid_i  = bus_a.in_valid_i;
    assign bus_b.instr_i     = bus_a.instr_i;
    assign bus_b.pc_i        = bus_a.pc_i;
    assign bus_b.out_ready_i = bus_a.out_ready_i;

    decode_pipe_stage #(.PC_W(32), .ENABLE_M(1'b1), .STALL_CNT_W(32)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_a.slave), .flush_i(flush_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .stall_o(stall_a), .stall_cnt_o(cnt_a)
    );
    decode_pipe_stage #(.PC_W(32), .ENABLE_M(1'b0), .STALL_CNT_W(4)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_b.slave), .flush_i(flush_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .stall_o(stall_b), .stall_cnt_o(cnt_b)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [19:0] ctrl;
    } dec_t;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic dec_t ref_decode(input logic [31:0] w, input bit em);
        int          op_tab [8];
        int          br_tab [8];
        int          ld_tab [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          alu, wid, m2r, imm;
        bit          src, rw, mr, mw, j, jr, mu, bad, u1, u2;
        dec_t        d;
        op_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        br_tab = '{10, 11, -1, -1, 12, 13, 14, 15};
        ld_tab = '{0, 1, 2, -1, 3, 4, -1, -1};
        f3 = w[14:12];
        f7 = w[31:25];
        alu = 0; wid = 0; m2r = 0; imm = 0;
        src = 0; rw = 0; mr = 0; mw = 0; j = 0; jr = 0; mu = 0; bad = 0; u1 = 0; u2 = 0;
        case (w[6:0])
            7'h37, 7'h17: begin rw = 1; src = 1; imm = int'(w & 32'hFFFF_F000); end
            7'h6F: begin
                rw = 1; j = 1; m2r = 2;
                imm = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11)
                      + (int'(w[30:21]) << 1);
            end
            7'h67: begin rw = 1; jr = 1; src = 1; m2r = 2; u1 = 1; imm = $signed(w) >>> 20; end
            7'h63: begin
                u1 = 1; u2 = 1;
                imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                if (br_tab[f3] < 0) bad = 1; else alu = br_tab[f3];
            end
            7'h03: begin
                rw = 1; mr = 1; src = 1; m2r = 1; u1 = 1; imm = $signed(w) >>> 20;
                if (ld_tab[f3] < 0) bad = 1; else wid = ld_tab[f3];
            end
            7'h23: begin
                mw = 1; src = 1; u1 = 1; u2 = 1; wid = int'(f3); bad = (f3 > 2);
                imm = (($signed(w) >>> 20) & ~31) | int'(w[11:7]);
            end
            7'h13: begin
                rw = 1; src = 1; u1 = 1;
                if (f3 == 1 || f3 == 5) begin
                    imm = int'(w[24:20]);
                    if (f3 == 1) begin alu = 2; bad = (f7 != 0); end
                    else if (f7 == 0) alu = 6;
                    else if (f7 == 7'h20) alu = 7;
                    else bad = 1;
                end else begin
                    imm = $signed(w) >>> 20;
                    alu = op_tab[f3];
                end
            end
            7'h33: begin
                rw = 1; u1 = 1; u2 = 1;
                if (f7 == 0) alu = op_tab[f3];
                else if (f7 == 7'h20 && f3 == 0) alu = 1;
                else if (f7 == 7'h20 && f3 == 5) alu = 7;
                else if (f7 == 7'h01 && em) mu = 1;
                else bad = 1;
            end
            7'h0F: begin u1 = 1; imm = $signed(w) >>> 20; end
            7'h73: begin u1 = 1; imm = $signed(w) >>> 20; bad = (f3 == 4); end
            default: bad = 1;
        endcase
        if (bad) begin rw = 0; mr = 0; mw = 0; j = 0; jr = 0; mu = 0; alu = 0; end
        d.rs1  = u1 ? w[19:15] : 5'd0;
        d.rs2  = u2 ? w[24:20] : 5'd0;
        d.rd   = rw ? w[11:7]  : 5'd0;
        d.imm  = imm;
        d.ctrl = {bad, (mu ? f3 : 3'b000), mu, jr, j, 2'(m2r), 3'(wid), mw, mr, rw, src, 4'(alu)};
        return d;
    endfunction

    bit          m_valid [2];
    logic [31:0] m_pc    [2];
    dec_t        m_dec   [2];
    logic [31:0] m_cnt   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_pc[k]    = '0;
            m_dec[k]   = '0;
            m_cnt[k]   = '0;
        end
    endtask

    // Compares one instance against the model for the inputs now applied; commit advances the model one edge.
    task automatic step_model(input int k, input bit commit);
        bit          hz, e_ov, e_ir;
        logic [31:0] cmax;
        string       p;
        dec_t        got;
        p    = (k == 0) ? "a" : "b";
        cmax = (k == 0) ? 32'hFFFF_FFFF : 32'd15;
        hz   = m_valid[k] && ex_memread_i && (ex_rd_i != 0) &&
               (ex_rd_i == m_dec[k].rs1 || ex_rd_i == m_dec[k].rs2);
        e_ov = m_valid[k] && !hz;
        e_ir = flush_i || ((!m_valid[k] || bus_a.out_ready_i) && !hz);
        if (k == 0) begin
            got = {bus_a.out_rs1_o, bus_a.out_rs2_o, bus_a.out_rd_o, bus_a.out_imm_o, bus_a.out_ctrl_o};
            chk({p, ".out_valid"}, bus_a.out_valid_o, e_ov);
            chk({p, ".in_ready"},  bus_a.in_ready_o, e_ir);
            chk({p, ".stall"},     stall_a, hz);
            chk({p, ".stall_cnt"}, cnt_a, m_cnt[k]);
            chk({p, ".pc"},        bus_a.out_pc_o, m_pc[k]);
        end else begin
            got = {bus_b.out_rs1_o, bus_b.out_rs2_o, bus_b.out_rd_o, bus_b.out_imm_o, bus_b.out_ctrl_o};
            chk({p, ".out_valid"}, bus_b.out_valid_o, e_ov);
            chk({p, ".in_ready"},  bus_b.in_ready_o, e_ir);
            chk({p, ".stall"},     stall_b, hz);
            chk({p, ".stall_cnt"}, {60'd0, cnt_b}, m_cnt[k]);
            chk({p, ".pc"},        bus_b.out_pc_o, m_pc[k]);
        end
        chk({p, ".regs"}, {49'd0, got.rs1, got.rs2, got.rd}, {49'd0, m_dec[k].rs1, m_dec[k].rs2, m_dec[k].rd});
        chk({p, ".imm"},  got.imm, m_dec[k].imm);
        chk({p, ".ctrl"}, got.ctrl, m_dec[k].ctrl);
        if (commit) begin
            if (flush_i) begin
                m_valid[k] = 0;
            end else if (bus_a.in_valid_i && e_ir) begin
                m_valid[k] = 1;
                m_pc[k]    = bus_a.pc_i;
                m_dec[k]   = ref_decode(bus_a.instr_i, k == 0);
            end else if (e_ov && bus_a.out_ready_i) begin
                m_valid[k] = 0;
            end
            if (hz && m_cnt[k] != cmax) m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                         input logic mr, input logic [4:0] erd, input logic ordy);
        bus_a.in_valid_i  = v;
        bus_a.instr_i     = ins;
        bus_a.pc_i        = pc;
        bus_a.out_ready_i = ordy;
        flush_i           = fl;
        ex_memread_i      = mr;
        ex_rd_i           = erd;
        #1;
        step_model(0, 1);
        step_model(1, 1);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        int          sel;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
        w   = $urandom;
        sel = $urandom_range(0, 12);
        if (sel < 11) w[6:0] = ops[sel];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        w[11:7]  = 5'($urandom_range(0, 3));
        return w;
    endfunction

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_ADD2  = 32'h0010_8133;
    localparam logic [31:0] I_SW    = 32'h0020_2223;
    localparam logic [31:0] I_LW3   = 32'h0080_A183;
    localparam logic [31:0] I_ADD4  = 32'h0001_8233;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;
    localparam logic [31:0] I_MUL   = 32'h0273_02B3;
    localparam logic [31:0] I_LW011 = 32'h0080_B183;

    initial begin
        bus_a.in_valid_i  = 0;
        bus_a.instr_i     = 0;
        bus_a.pc_i        = 0;
        bus_a.out_ready_i = 0;
        flush_i = 0; ex_memread_i = 0; ex_rd_i = 0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        step_model(0, 0);
        step_model(1, 0);
        rst_ni = 1'b1;

        cycle(1, I_ADDI, 32'h100, 0, 0, 0, 1);
        chk("t1.valid0", bus_a.out_valid_o, 1);
        chk("t1.imm0", bus_a.out_imm_o, 5);
        cycle(1, I_ADD2, 32'h104, 0, 0, 0, 1);
        chk("t1.valid1", bus_a.out_valid_o, 1);
        chk("t1.imm1", bus_a.out_imm_o, 0);
        cycle(1, I_SW, 32'h108, 0, 0, 0, 1);
        chk("t1.valid2", bus_a.out_valid_o, 1);
        chk("t1.imm2", bus_a.out_imm_o, 4);
        chk("t1.width", bus_a.out_ctrl_o[10:8], 3'b010);
        chk("t1.memwrite", bus_a.out_ctrl_o[7], 1);
        cycle(0, 0, 0, 0, 0, 0, 1);

        cycle(1, I_LW3, 32'h200, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
        chk("t2.in_ready", bus_a.in_ready_o, 0);
        chk("t2.rd", bus_a.out_rd_o, 3);
        chk("t2.imm", bus_a.out_imm_o, 8);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t2.drained", bus_a.out_valid_o, 0);

        cycle(1, I_ADD4, 32'h300, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 5'd3, 1);
        chk("t3.stall", stall_a, 1);
        chk("t3.bubble", bus_a.out_valid_o, 0);
        chk("t3.cnt", cnt_a, 1);
        cycle(0, 0, 0, 0, 1, 5'd0, 1);
        chk("t3.x0_cnt", cnt_a, 1);
        chk("t3.x0_drained", bus_a.out_valid_o, 0);

        cycle(1, I_ADD4, 32'h304, 0, 0, 0, 0);
        repeat (20) cycle(0, 0, 0, 0, 1, 5'd3, 0);
        chk("sat.cnt_b", cnt_b, 15);
        chk("sat.cnt_a", cnt_a, 21);
        cycle(0, 0, 0, 0, 0, 0, 1);

        cycle(1, I_BEQ, 32'h400, 0, 0, 0, 0);
        cycle(1, I_JAL, 32'h404, 1, 0, 0, 0);
        chk("flush.valid0", bus_a.out_valid_o, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("flush.valid1", bus_a.out_valid_o, 0);

        cycle(1, I_MUL, 32'h500, 0, 0, 0, 1);
        chk("mul.a_mul", bus_a.out_ctrl_o[15], 1);
        chk("mul.a_mulop", bus_a.out_ctrl_o[18:16], 0);
        chk("mul.b_illegal", bus_b.out_ctrl_o[19], 1);
        chk("mul.b_regwrite", bus_b.out_ctrl_o[5], 0);
        chk("mul.b_rd", bus_b.out_rd_o, 0);
        cycle(1, 32'h0, 32'h504, 0, 0, 0, 1);
        chk("ill.opcode0", bus_a.out_ctrl_o[19], 1);
        cycle(1, I_LW011, 32'h508, 0, 0, 0, 1);
        chk("ill.lw011", bus_a.out_ctrl_o[19], 1);

        cycle(1, I_ADDI, 32'h600, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        model_reset();
        step_model(0, 0);
        step_model(1, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_instr(), $urandom, ($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Registered, handshaked instruction-decode stage for the RV32I(M) SoC, the pipelined successor of the purely combinational decoder. Sits between fetch and EX: accepts one instruction per cycle on a valid/ready interface, decodes it into a packed control bundle, checks the instruction about to enter EX for a load-use hazard, flags illegal encodings, supports pipeline flush, and counts hazard-stall cycles. Optional M-extension decode is selected by parameter.

## Interface
- PC_W, 32, width of program counter carried with the instruction
- ENABLE_M, 1, 1 = decode funct7=0000001 R-type as MUL/DIV; 0 = flag it illegal
- STALL_CNT_W, 32, width of saturating stall counter
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- in_valid_i  in  1  fetch presents instruction
- in_ready_o  out  1  stage accepts beat this cycle
- instr_i  in  32  instruction word
- pc_i  in  PC_W  instruction address
- flush_i  in  1  synchronous kill of held and incoming instruction
- ex_memread_i  in  1  instruction currently in EX is a load
- ex_rd_i  in  5  destination of instruction in EX
- out_valid_o  out  1  decoded instruction valid toward EX
- out_ready_i  in  1  EX accepts
- out_pc_o  out  PC_W  registered PC
- out_rs1_o, out_rs2_o, out_rd_o  out  5 each  register addresses (0 when unused)
- out_imm_o  out  32  selected immediate
- out_ctrl_o  out  20  packed control bundle (layout below)
- stall_o  out  1  load-use hazard active this cycle
- stall_cnt_o  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- ctrl layout: [3:0] aluop (ADD=0,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND=9, BEQ=A,BNE,BLT,BGE,BLTU,BGEU=F); [4] alusrc; [5] regwrite; [6] memread; [7] memwrite; [10:8] width (loads 000 LB,001 LH,010 LW,011 LBU,100 LHU; stores 000 SB,001 SH,010 SW); [12:11] memtoreg (00 ALU,01 MEM,10 PC+4); [13] jal; [14] jalr; [15] mul; [18:16] mulop = funct3; [19] illegal.
- Decode is combinational from instr_i; result captured in the output register on accept (in_valid_i && in_ready_o).
- Immediates: I, S, B, U, J per RV32I; OP-IMM shifts give zero-extended shamt; others 0.
- rs1 used by all except LUI/AUIPC/JAL; rs2 used only by R, S, B; unused fields output 0. rd output 0 unless regwrite.
- Illegal: unknown opcode; load funct3 in {011,110,111}; store funct3 > 010; branch funct3 in {010,011}; R-type funct7 not 0000000, not 0100000 with funct3 000/101, not 0000001 with ENABLE_M=1; OP-IMM shift with bad funct7; SYSTEM funct3=100. Illegal forces regwrite, memread, memwrite, jal, jalr, mul to 0, aluop ADD, sets bit 19; still delivered downstream (trap handled in EX).
- Hazard (stall_o) = out_valid_reg && ex_memread_i && ex_rd_i != 0 && (ex_rd_i == out_rs1_o || ex_rd_i == out_rs2_o), using the zero-forced addresses.
- During hazard: out_valid_o = 0 (bubble into EX), output register holds, in_ready_o = 0, stall_cnt_o += 1 saturating at all-ones.
- in_ready_o = flush_i || ((!out_valid_reg || out_ready_i) && !stall_o).
- flush_i: next edge clears out_valid_reg; beat offered in same cycle is consumed and discarded; flush has priority over hazard and accept. Stall counter unaffected by flush.

## Timing
- Reset: out_valid_o 0, all payload outputs 0, stall_cnt_o 0, stall_o 0; in_ready_o 1 after reset.
- Latency: 1 cycle accept -> out_valid_o. Throughput 1/cycle with out_ready_i held high and no hazard.
- Backpressure: out_valid_o && !out_ready_i holds all payload stable; in_ready_o 0.
- Accept and drain in same cycle: new beat replaces old on that edge, no bubble.
- Hazard lasts exactly while condition holds (normally 1 cycle); payload stays visible though out_valid_o is low.
- Reset asserted mid-transfer: outputs go to reset values immediately, held instruction lost.

## Test plan
- Stream ADDI x1,x0,5 / ADD x2,x1,x1 / SW x2,4(x0) with out_ready_i=1 -> three consecutive out_valid_o cycles, imm 5/0/4, ctrl width 010 and memwrite on third.
- Hold out_ready_i=0 for 3 cycles after LW x3,8(x1) accepted -> payload stable, in_ready_o=0, then single transfer on release.
- ex_memread_i=1, ex_rd_i=3 while held ADD x4,x3,x0 -> stall_o=1, out_valid_o=0 one cycle, stall_cnt_o 0->1; ex_rd_i=0 never stalls.
- flush_i with held BEQ and incoming JAL -> next cycle out_valid_o=0, neither appears.
- MUL x5,x6,x7 with ENABLE_M=1 -> ctrl[15]=1, mulop 000; ENABLE_M=0 -> ctrl[19]=1, regwrite 0, rd 0.
- Opcode 0000000 and LW funct3=011 -> illegal bit set; STALL_CNT_W=4 with 20 stall cycles -> counter saturates at 15.
